// File: rtl/decode_regfile_if.sv
// Decode-stage bus bundle: fetch handshake, execute writeback port and the issue slot.
// The master side drives instructions and writeback; the slave side is the decode stage.
interface decode_regfile_if #(
    parameter int DATA_W      = 8,
    parameter int STALL_CNT_W = 8
);
    logic [15:0]            i_instr;
    logic                   i_instr_valid;
    logic                   o_instr_ready;
    logic                   i_wb_en;
    logic [3:0]             i_wb_add;
    logic [DATA_W-1:0]      i_wb_data;
    logic [3:0]             o_opcode;
    logic [DATA_W-1:0]      o_srcdata_1;
    logic [DATA_W-1:0]      o_srcdata_2;
    logic [3:0]             o_destadd;
    logic                   o_issue_valid;
    logic [STALL_CNT_W-1:0] o_stall_cnt;

    modport master (
        output i_instr, i_instr_valid, i_wb_en, i_wb_add, i_wb_data,
        input  o_instr_ready, o_opcode, o_srcdata_1, o_srcdata_2, o_destadd,
               o_issue_valid, o_stall_cnt
    );

    modport slave (
        input  i_instr, i_instr_valid, i_wb_en, i_wb_add, i_wb_data,
        output o_instr_ready, o_opcode, o_srcdata_1, o_srcdata_2, o_destadd,
               o_issue_valid, o_stall_cnt
    );
endinterface

// File: rtl/decode_regfile.sv
// Decode stage of the FDE CPU: field split, bypassed register-file read, one-bubble
// interlock against the instruction currently in the issue slot, registered issue output.
module decode_regfile #(
    parameter int DATA_W      = 8,
    parameter int NREG        = 16,
    parameter int STALL_CNT_W = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    decode_regfile_if.slave bus
);

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_LS  = 4'b0100,
        OP_RS  = 4'b1000
    } opcode_e;

    logic [DATA_W-1:0]      regs_q [NREG];
    opcode_e                opcode_q, opcode_d;
    logic [DATA_W-1:0]      src1_q, src1_d, src2_q, src2_d;
    logic [3:0]             dest_q, dest_d;
    logic                   issue_q, issue_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [3:0]             pend_dest_q, pend_dest_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic [3:0]        op_f, dest_f, src1_f, src2_f;
    logic              reads1, reads2, hazard, accept;
    logic [DATA_W-1:0] rd1, rd2;

    assign op_f   = bus.i_instr[15:12];
    assign dest_f = bus.i_instr[11:8];
    assign src1_f = bus.i_instr[7:4];
    assign src2_f = bus.i_instr[3:0];

    always_comb begin
        reads1 = 1'b0;
        reads2 = 1'b0;
        case (op_f)
            OP_ADD, OP_SUB: begin
                reads1 = 1'b1;
                reads2 = 1'b1;
            end
            OP_LS, OP_RS: reads1 = 1'b1;
            default: ;
        endcase
    end

    // Same-cycle writeback wins over the stored value, covering the producer two ahead.
    always_comb begin
        rd1 = regs_q[src1_f];
        rd2 = regs_q[src2_f];
        if (bus.i_wb_en && (bus.i_wb_add == src1_f)) rd1 = bus.i_wb_data;
        if (bus.i_wb_en && (bus.i_wb_add == src2_f)) rd2 = bus.i_wb_data;
    end

    assign hazard = bus.i_instr_valid && pend_vld_q &&
                    ((reads1 && (pend_dest_q == src1_f)) ||
                     (reads2 && (pend_dest_q == src2_f)));
    assign accept = bus.i_instr_valid && !hazard;
    assign bus.o_instr_ready = !hazard;

    always_comb begin
        opcode_d    = OP_NOP;
        src1_d      = '0;
        src2_d      = '0;
        dest_d      = '0;
        issue_d     = 1'b0;
        pend_vld_d  = 1'b0;
        pend_dest_d = '0;
        stall_d     = stall_q;
        if (hazard && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
        if (accept) begin
            issue_d = 1'b1;
            if (reads1) begin
                opcode_d    = opcode_e'(op_f);
                dest_d      = dest_f;
                src1_d      = rd1;
                pend_vld_d  = 1'b1;
                pend_dest_d = dest_f;
            end
            if (reads2) begin
                src2_d = rd2;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.i_wb_en) begin
            regs_q[bus.i_wb_add] <= bus.i_wb_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            opcode_q    <= OP_NOP;
            src1_q      <= '0;
            src2_q      <= '0;
            dest_q      <= '0;
            issue_q     <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_dest_q <= '0;
            stall_q     <= '0;
        end else begin
            opcode_q    <= opcode_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            dest_q      <= dest_d;
            issue_q     <= issue_d;
            pend_vld_q  <= pend_vld_d;
            pend_dest_q <= pend_dest_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.o_opcode      = opcode_q;
    assign bus.o_srcdata_1   = src1_q;
    assign bus.o_srcdata_2   = src2_q;
    assign bus.o_destadd     = dest_q;
    assign bus.o_issue_valid = issue_q;
    assign bus.o_stall_cnt   = stall_q;

endmodule
